// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - plays the stored memory-game sequence on the LEDs, one ROM entry at a time
module exibe_sequencia #(
    parameter int T_ON  = 500,
    parameter int T_OFF = 250,
    parameter int TW    = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic [3:0] limite,
    output logic [3:0] rom_endereco,
    input  logic [3:0] rom_dado,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado,
    output logic [3:0] db_limite
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        CARREGA = 3'd2,
        EXIBE   = 3'd3,
        APAGA   = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    estado_t       estado_q, estado_d;
    logic [3:0]    endereco_q, endereco_d;
    logic [3:0]    leds_q, leds_d;
    logic [3:0]    limite_q, limite_d;
    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        limite_d   = limite_q;
        timer_d    = timer_q;
        case (estado_q)
            OCIOSO: begin
                leds_d = 4'd0;
                if (iniciar) begin
                    limite_d   = limite;
                    endereco_d = 4'd0;
                    estado_d   = BUSCA;
                end
            end
            BUSCA: estado_d = CARREGA;
            CARREGA: begin
                leds_d   = rom_dado;
                timer_d  = '0;
                estado_d = EXIBE;
            end
            EXIBE: begin
                if (timer_q == ON_LAST) begin
                    leds_d   = 4'd0;
                    timer_d  = '0;
                    estado_d = APAGA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            APAGA: begin
                leds_d = 4'd0;
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    // The last address ends the run here, so the address never wraps past 15.
                    if (endereco_q == limite_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + 4'd1;
                        estado_d   = BUSCA;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FIM: estado_d = OCIOSO;
            default: begin
                estado_d = OCIOSO;
                leds_d   = 4'd0;
                timer_d  = '0;
            end
        endcase
        // Abort overrides every other transition, including a simultaneous start.
        if (cancelar) begin
            estado_d   = OCIOSO;
            leds_d     = 4'd0;
            timer_d    = '0;
            limite_d   = limite_q;
            endereco_d = endereco_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= 4'd0;
            leds_q     <= 4'd0;
            limite_q   <= 4'd0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            limite_q   <= limite_d;
            timer_q    <= timer_d;
        end
    end

    assign rom_endereco = endereco_q;
    assign leds         = leds_q;
    assign ocupado      = (estado_q != OCIOSO);
    assign pronto       = (estado_q == FIM);
    assign db_estado    = estado_q;
    assign db_limite    = limite_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// tb/tb_exibe_sequencia.sv - scoreboard bench for exibe_sequencia against a per-cycle trace model
module tb_exibe_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int ENTRY = 2 + T_ON + T_OFF;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       cancelar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] rom_endereco;
    logic [3:0] rom_dado = 4'd0;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;
    logic [3:0] db_limite;

    logic [3:0] rom [16];

    typedef struct packed {
        logic [3:0] leds;
        logic       ocupado;
        logic       pronto;
        logic [3:0] addr;
        logic       chk_addr;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .TW(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
        .limite(limite), .rom_endereco(rom_endereco), .rom_dado(rom_dado),
        .leds(leds), .ocupado(ocupado), .pronto(pronto),
        .db_estado(db_estado), .db_limite(db_limite)
    );

    always #5 clock = ~clock;

    // Synchronous 16x4 ROM: data appears one edge after the address.
    always @(posedge clock) rom_dado <= rom[rom_endereco];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] l, input logic o, input logic p,
                                input logic [3:0] a, input logic c);
        exp_t e;
        e.leds = l; e.ocupado = o; e.pronto = p; e.addr = a; e.chk_addr = c;
        return e;
    endfunction

    // Each entry: fetch+load blank cycles, value for T_ON, blank for T_OFF; then one pronto cycle.
    task automatic push_run(input int lim);
        for (int i = 0; i <= lim; i++) begin
            repeat (2) q.push_back(mk(4'd0, 1'b1, 1'b0, 4'(i), 1'b1));
            repeat (T_ON) q.push_back(mk(rom[i], 1'b1, 1'b0, 4'(i), 1'b1));
            repeat (T_OFF) q.push_back(mk(4'd0, 1'b1, 1'b0, 4'(i), 1'b1));
        end
        q.push_back(mk(4'd0, 1'b1, 1'b1, 4'(lim), 1'b1));
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("leds", 16'(leds), 16'(e.leds));
            check("ocupado", 16'(ocupado), 16'(e.ocupado));
            check("pronto", 16'(pronto), 16'(e.pronto));
            if (e.chk_addr) check("rom_endereco", 16'(rom_endereco), 16'(e.addr));
        end else begin
            check("idle_leds", 16'(leds), 16'd0);
            check("idle_ocupado", 16'(ocupado), 16'd0);
            check("idle_pronto", 16'(pronto), 16'd0);
        end
    end

    task automatic start(input int lim);
        limite = 4'(lim);
        @(posedge clock); #1;
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        push_run(lim);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 3000) begin
            @(posedge clock);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(posedge clock); #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(i);
        rom[0] = 4'hA;
        iniciar = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_leds", 16'(leds), 16'd0);
        check("rst_addr", 16'(rom_endereco), 16'd0);
        check("rst_ocupado", 16'(ocupado), 16'd0);
        check("rst_pronto", 16'(pronto), 16'd0);
        iniciar = 1'b0;
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        // Single entry, ROM[0]=A.
        start(0);
        drain();

        // Full 16-entry sequence, no wrap at address 15.
        for (int i = 0; i < 16; i++) rom[i] = 4'(i);
        start(15);
        drain();
        check("addr_end_15", 16'(rom_endereco), 16'd15);

        // Cancel during EXIBE of address 2, then restart.
        fill_random();
        start(5);
        repeat (19) @(posedge clock);
        #1; cancelar = 1'b1;
        @(posedge clock); #1;
        cancelar = 1'b0;
        q.delete();
        repeat (3) @(posedge clock);
        #1;
        start(2);
        drain();

        // Re-pulsed iniciar during APAGA and limite change mid-run are ignored.
        fill_random();
        start(3);
        repeat (6) @(posedge clock);
        #1; iniciar = 1'b1; limite = 4'd1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        drain();

        // iniciar and cancelar together in OCIOSO.
        iniciar = 1'b1; cancelar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0; cancelar = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // iniciar held across FIM: accepted only from the following idle cycle.
        begin
            int len2, n;
            fill_random();
            limite = 4'd1;
            @(posedge clock); #1;
            iniciar = 1'b1;
            @(posedge clock); #1;
            push_run(1);
            q.push_back(mk(4'd0, 1'b0, 1'b0, 4'd0, 1'b0));
            push_run(1);
            len2 = 2 * ENTRY + 1;
            n = 0;
            while (q.size() >= len2 && n < 200) begin
                @(posedge clock); #1;
                n++;
            end
            iniciar = 1'b0;
            drain();
        end

        // Asynchronous reset between edges in EXIBE.
        fill_random();
        start(4);
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        q.delete();
        #1;
        check("async_leds", 16'(leds), 16'd0);
        check("async_addr", 16'(rom_endereco), 16'd0);
        check("async_ocupado", 16'(ocupado), 16'd0);
        check("async_pronto", 16'(pronto), 16'd0);
        repeat (2) @(posedge clock);
        #1; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        start(1);
        drain();

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            start($urandom_range(0, 15));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Presents the stored memory-game sequence to the player. It is the output side of the game datapath: the checker compares the player's switch inputs against the ROM, while this block reads the same sync_rom_16x4 contents and drives them onto the LEDs.
- Each entry from address 0 up to a programmable limit is lit for T_ON clock cycles, then blanked for T_OFF cycles.
- Completion is reported with a one-cycle pulse to the game control unit.

Parameters:
- T_ON, 500, cycles each sequence value is shown on the LEDs (must be ≥1).
- T_OFF, 250, blank cycles after each value (must be ≥1).
- TW, 12, timer width in bits; T_ON-1 and T_OFF-1 must fit in TW bits.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request; sampled only in OCIOSO.
- cancelar  in  1  synchronous abort; returns to OCIOSO.
- limite  in  4  last ROM address to present, inclusive; sampled when iniciar is accepted.
- rom_endereco  out  4  address to the external sync ROM; registered.
- rom_dado  in  4  ROM data; valid one clock edge after rom_endereco changes.
- leds  out  4  value shown to the player; registered; 0 means blank.
- ocupado  out  1  high in every state except OCIOSO.
- pronto  out  1  one-cycle pulse at the end of the sequence.
- db_estado  out  3  state code for debug.
- db_limite  out  4  latched limit, for debug.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state OCIOSO; rom_endereco=0; leds=0; timer=0; latched limit=0.
  - ocupado=0; pronto=0.
- State codes: OCIOSO=0, BUSCA=1, CARREGA=2, EXIBE=3, APAGA=4, FIM=5. Codes 6 and 7 go to OCIOSO.
- OCIOSO:
  - leds=0.
  - On iniciar=1: latch limite, set rom_endereco=0, go to BUSCA.
- BUSCA (1 cycle): rom_endereco is held stable so the ROM can register the data. Go to CARREGA.
- CARREGA (1 cycle): rom_dado is valid. leds<=rom_dado at the exiting edge, timer<=0. Go to EXIBE.
- EXIBE:
  - leds hold the captured value; timer increments each cycle.
  - When timer==T_ON-1: leds<=0, timer<=0, go to APAGA. The value is therefore visible for exactly T_ON cycles.
- APAGA:
  - leds=0; timer increments each cycle.
  - When timer==T_OFF-1 and rom_endereco==latched limit: go to FIM.
  - When timer==T_OFF-1 and rom_endereco differs from the limit: rom_endereco+1, go to BUSCA.
- FIM (1 cycle): pronto=1, ocupado=1. Go to OCIOSO.
- Timing from iniciar accepted at edge k:
  - BUSCA starts at cycle k+1.
  - Each entry occupies 2+T_ON+T_OFF cycles.
  - FIM is reached (L+1)*(2+T_ON+T_OFF) cycles after BUSCA entry, where L is the latched limit.
- Boundary conditions:
  - limite=0: exactly one value is presented.
  - limite=15: all 16 entries are presented. rom_endereco never wraps; the increment never happens at 15.
  - iniciar while ocupado=1: ignored. Changing limite mid-sequence has no effect.
  - cancelar=1 in any state: next edge gives OCIOSO, leds=0, timer=0, no pronto pulse. cancelar has priority over every transition, including iniciar in the same cycle.
  - iniciar high in the FIM cycle: ignored; it is accepted on the next cycle in OCIOSO if still high.
  - reset asserted mid-sequence: all outputs take their reset values immediately, without waiting for a clock edge.
- No combinational path from inputs to outputs; every output is registered or decoded from registered state.

Test Plan:
- Reset: hold reset=0 during activity → leds=0, rom_endereco=0, ocupado=0, pronto=0 immediately; after release the block stays in OCIOSO until iniciar.
- Single entry, T_ON=4, T_OFF=2, ROM[0]=4'hA, limite=0, iniciar pulse:
  - leds=A for exactly 4 cycles, starting 3 cycles after the iniciar edge.
  - then 2 cycles of 0, then pronto high for 1 cycle.
  - ocupado high for 9 cycles.
- Full sequence, ROM=0..F pattern, limite=15 → 16 LED windows in address order; pronto 128 cycles after BUSCA entry; rom_endereco ends at 15 with no wrap.
- Cancel: cancelar asserted during EXIBE of address 2 → next cycle leds=0, ocupado=0, no pronto. A later iniciar restarts at address 0.
- Ignored inputs:
  - iniciar re-pulsed during APAGA → no restart.
  - limite changed from 3 to 1 mid-run → still 4 entries presented.
  - iniciar and cancelar together in OCIOSO → stays in OCIOSO.
- Asynchronous reset between edges in EXIBE → outputs clear before the next clock edge; normal operation resumes after release.
